// File: rtl/dram_ctrl.sv
// Single-outstanding CPU-to-DRAM bridge. It handles byte, half and word loads and
// stores over a shared tri-state bus. Sub-word stores use read-modify-write.
module dram_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] dram_address,
  output logic              dram_wren,
  inout  wire  [WORD_W-1:0] dram_data
);

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;
  // Highest start address whose 4-byte window still fits in the array.
  localparam logic [ADDR_W-1:0] AddrMax = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {StIdle, StRd, StRmw, StWr, StResp, StErr} state_e;

  state_e            state_q, state_d;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] dram_address_q;
  logic              dram_wren_q;
  logic [WORD_W-1:0] wr_word_q;
  logic [WORD_W-1:0] rdata_q;
  logic              accept;
  logic              acc_err;
  logic [WORD_W-1:0] load_word;
  logic [WORD_W-1:0] merge_word;

  assign accept       = req_valid && (state_q == StIdle);
  assign req_ready    = (state_q == StIdle);
  assign rsp_valid    = (state_q == StResp) || (state_q == StErr);
  assign rsp_err      = (state_q == StErr);
  assign rsp_rdata    = rdata_q;
  assign dram_address = dram_address_q;
  assign dram_wren    = dram_wren_q;
  // Drive the bus only while the write-enable flop is set, so the array never fights us.
  assign dram_data    = dram_wren_q ? wr_word_q : {WORD_W{1'bz}};

  // Alignment, size and range check on the incoming request.
  always_comb begin
    acc_err = 1'b0;
    case (req_size)
      SzByte:  acc_err = 1'b0;
      SzHalf:  acc_err = req_addr[0];
      SzWord:  acc_err = |req_addr[1:0];
      default: acc_err = 1'b1;
    endcase
    if (req_addr > AddrMax) acc_err = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (acc_err)               state_d = StErr;
          else if (!req_we)          state_d = StRd;
          else if (req_size == SzWord) state_d = StWr;
          else                       state_d = StRmw;
        end
      end
      StRd:    state_d = StResp;
      StRmw:   state_d = StWr;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Extend the bus word into a load result for the latched size.
  always_comb begin
    load_word = dram_data;
    case (size_q)
      SzByte:  load_word = {{(WORD_W-8){~unsigned_q & dram_data[7]}}, dram_data[7:0]};
      SzHalf:  load_word = {{(WORD_W-16){~unsigned_q & dram_data[15]}}, dram_data[15:0]};
      default: load_word = dram_data;
    endcase
  end

  // Insert the store bytes into the word read back during RMW.
  always_comb begin
    merge_word = dram_data;
    case (size_q)
      SzByte:  merge_word = {dram_data[WORD_W-1:8], wdata_q[7:0]};
      SzHalf:  merge_word = {dram_data[WORD_W-1:16], wdata_q[15:0]};
      default: merge_word = dram_data;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Request latch, DRAM-side registers and load result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      size_q         <= 2'b00;
      unsigned_q     <= 1'b0;
      wdata_q        <= '0;
      dram_address_q <= '0;
      dram_wren_q    <= 1'b0;
      wr_word_q      <= '0;
      rdata_q        <= '0;
    end else begin
      dram_wren_q <= (state_d == StWr);
      if (accept) begin
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata[15:0];
        // Rejected requests never touch the array, so keep the old address.
        if (!acc_err) dram_address_q <= req_addr;
        if (!acc_err && req_we && (req_size == SzWord)) wr_word_q <= req_wdata;
      end
      if (state_q == StRmw) wr_word_q <= merge_word;
      if (state_q == StRd)  rdata_q   <= load_word;
    end
  end

endmodule
